// File: rtl/csr_issue_pkg.sv
// Shared field positions, state encodings and small helpers for the CSR issue scheduler.
package csr_issue_pkg;

    localparam int IMM_L_BIT = 112;
    localparam int IMM_R_BIT = 111;
    localparam int DEP_HI    = 110;
    localparam int DEP_LO    = 107;
    localparam int IMM_HI    = 106;
    localparam int IMM_LO    = 75;
    localparam int CSR_HI    = 45;
    localparam int CSR_LO    = 34;
    localparam int RS1_HI    = 28;
    localparam int RS1_LO    = 24;

    localparam logic [3:0] NODEP = 4'hF;

    typedef logic [1:0] schedState_t;
    localparam schedState_t IDLE  = 2'd0;
    localparam schedState_t LOAD  = 2'd1;
    localparam schedState_t FETCH = 2'd2;
    localparam schedState_t ISSUE = 2'd3;

    // A tag of all ones means the left operand is already architectural (GRF).
    function automatic logic isGrfDep(input logic [3:0] dep);
        return dep == NODEP;
    endfunction

endpackage

// File: rtl/csr_gray_queue.sv
// In-order instruction queue with binary/Gray pointers, registered empty and registered head read.
module csr_gray_queue #(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 5,
    parameter int INSN_W = 113
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              enqValid,
    input  logic [INSN_W-1:0] enqInsn,
    output logic              enqReady,
    input  logic              deq,
    output logic [INSN_W-1:0] headInsn,
    output logic              empty,
    output logic [PTR_W-1:0]  rdPtrGray,
    output logic [PTR_W-1:0]  wrPtrGray
);

    localparam int AW = PTR_W - 1;
    localparam logic [PTR_W-1:0] FULL_MASK = {2'b11, {(PTR_W-2){1'b0}}};

    logic [INSN_W-1:0] mem [DEPTH];
    logic [INSN_W-1:0] headReg;
    logic [PTR_W-1:0]  rdBin, wrBin, rdBinNext, wrBinNext;
    logic              emptyReg, full, doEnq, doDeq;

    function automatic logic [PTR_W-1:0] toGray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign rdPtrGray = toGray(rdBin);
    assign wrPtrGray = toGray(wrBin);
    assign full      = (wrPtrGray == (rdPtrGray ^ FULL_MASK));
    assign enqReady  = !full && !flush;
    assign doEnq     = enqValid && enqReady;
    assign doDeq     = deq && !emptyReg;
    assign empty     = emptyReg;
    assign headInsn  = headReg;

    always_comb begin
        rdBinNext = rdBin + PTR_W'(doDeq);
        wrBinNext = wrBin + PTR_W'(doEnq);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdBin    <= '0;
            wrBin    <= '0;
            emptyReg <= 1'b1;
        end else if (flush) begin
            rdBin    <= '0;
            wrBin    <= '0;
            emptyReg <= 1'b1;
        end else begin
            rdBin    <= rdBinNext;
            wrBin    <= wrBinNext;
            emptyReg <= (toGray(rdBinNext) == toGray(wrBinNext));
        end
    end

    // Head is read one cycle ahead; the scheduler never loads an entry written on the same edge.
    always_ff @(posedge clk) begin
        if (doEnq)
            mem[wrBin[AW-1:0]] <= enqInsn;
        headReg <= mem[rdBin[AW-1:0]];
    end

endmodule

// File: rtl/csr_issue_sched.sv
// CSR issue scheduler: queues decoded instructions, fetches GRF/bypass and CSR operands, issues to execute.
module csr_issue_sched
    import csr_issue_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 5,
    parameter int INSN_W = 113,
    parameter int DEP_W  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [INSN_W-1:0]    enq_insn,
    input  logic                 flush,
    output logic                 empty,
    output logic [PTR_W-1:0]     rd_ptr_gray,
    output logic [PTR_W-1:0]     wr_ptr_gray,
    output logic                 grf_req,
    input  logic                 grf_ack,
    output logic                 byp_req,
    input  logic                 byp_ack,
    output logic [DEP_W-1:0]     byp_dep,
    output logic                 csr_req,
    input  logic                 csr_ack,
    output logic [4:0]           rs1_idx,
    output logic [11:0]          csr_addr,
    input  logic [31:0]          opnd_l,
    input  logic [31:0]          opnd_r,
    output logic                 exe_valid,
    input  logic                 exe_ready,
    output logic [INSN_W+63:0]   exe_insn
);

    schedState_t       state;
    logic [INSN_W-1:0] headInsn, workInsn;
    logic [31:0]       opL, opR;
    logic              grfReq, bypReq, csrReq, exeValid;
    logic [4:0]        rs1Idx;
    logic [11:0]       csrAddr;
    logic [DEP_W-1:0]  bypDep;
    logic              deq;

    logic              hImmL, hImmR;
    logic [DEP_W-1:0]  hDep;
    logic [31:0]       hImm;
    logic              needGrf, needByp, needCsr;
    logic              grfLeft, bypLeft, csrLeft;

    csr_gray_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .INSN_W(INSN_W)
    ) queue (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush),
        .enqValid (enq_valid),
        .enqInsn  (enq_insn),
        .enqReady (enq_ready),
        .deq      (deq),
        .headInsn (headInsn),
        .empty    (empty),
        .rdPtrGray(rd_ptr_gray),
        .wrPtrGray(wr_ptr_gray)
    );

    assign deq = (state == LOAD);

    assign hImmL   = headInsn[IMM_L_BIT];
    assign hImmR   = headInsn[IMM_R_BIT];
    assign hDep    = headInsn[DEP_HI:DEP_LO];
    assign hImm    = headInsn[IMM_HI:IMM_LO];
    assign needGrf = !hImmL && isGrfDep(hDep);
    assign needByp = !hImmL && !isGrfDep(hDep);
    assign needCsr = !hImmR;

    // A request is still outstanding if its ack has not been seen on this edge.
    assign grfLeft = grfReq && !grf_ack;
    assign bypLeft = bypReq && !byp_ack;
    assign csrLeft = csrReq && !csr_ack;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            workInsn <= '0;
            opL      <= '0;
            opR      <= '0;
            grfReq   <= 1'b0;
            bypReq   <= 1'b0;
            csrReq   <= 1'b0;
            exeValid <= 1'b0;
            rs1Idx   <= '0;
            csrAddr  <= '0;
            bypDep   <= '0;
        end else if (flush) begin
            state    <= IDLE;
            grfReq   <= 1'b0;
            bypReq   <= 1'b0;
            csrReq   <= 1'b0;
            exeValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty)
                        state <= LOAD;
                end
                LOAD: begin
                    workInsn <= headInsn;
                    rs1Idx   <= headInsn[RS1_HI:RS1_LO];
                    csrAddr  <= headInsn[CSR_HI:CSR_LO];
                    bypDep   <= hDep;
                    opL      <= hImmL ? hImm : '0;
                    opR      <= hImmR ? hImm : '0;
                    grfReq   <= needGrf;
                    bypReq   <= needByp;
                    csrReq   <= needCsr;
                    if (needGrf || needByp || needCsr) begin
                        state <= FETCH;
                    end else begin
                        state    <= ISSUE;
                        exeValid <= 1'b1;
                    end
                end
                FETCH: begin
                    if (grfReq && grf_ack) begin
                        opL    <= opnd_l;
                        grfReq <= 1'b0;
                    end
                    if (bypReq && byp_ack) begin
                        opL    <= opnd_l;
                        bypReq <= 1'b0;
                    end
                    if (csrReq && csr_ack) begin
                        opR    <= opnd_r;
                        csrReq <= 1'b0;
                    end
                    if (!grfLeft && !bypLeft && !csrLeft) begin
                        state    <= ISSUE;
                        exeValid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exe_ready) begin
                        exeValid <= 1'b0;
                        state    <= empty ? IDLE : LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign grf_req   = grfReq;
    assign byp_req   = bypReq;
    assign csr_req   = csrReq;
    assign byp_dep   = bypDep;
    assign rs1_idx   = rs1Idx;
    assign csr_addr  = csrAddr;
    assign exe_valid = exeValid;
    assign exe_insn  = {workInsn, opL, opR};

endmodule
